subst_vector_checker: RTL

Exhaustive stimulus-and-check stage placed around the 8-input substitution example netlist (inputs a..h, output out) and its ABC-optimised counterparts. It drives every input combination into the netlist, takes the single-bit out back, and compares it against the golden simplified function out = a & b & ~c. It reports the mismatch count and the first failing vector. This gives a cycle-accurate equivalence check for each optimised netlist we generate.

---
 rtl/subst_vector_checker.sv | 111 +++++++++++
 1 files changed

// File: rtl/subst_vector_checker.sv
// Exhaustive sweep of an N_IN-input netlist against out = a & b & ~c.
// Counts mismatches and latches the first failing vector of each sweep.
module subst_vector_checker #(
  parameter int N_IN  = 8,
  parameter int CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec_out,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};

  state_t           state;
  logic             golden;
  logic             miss;
  logic             last;
  logic             go;
  logic [CNT_W-1:0] cnt_nx;

  assign golden = vec_out[N_IN-1]
                & vec_out[N_IN-2]
                & ~vec_out[N_IN-3];
  assign miss   = dut_out ^ golden;
  assign last   = (vec_out == VEC_MAX);
  assign go     = start & ~abort & (state != RUN);

  // Saturate rather than wrap, even though a full sweep cannot overflow.
  assign cnt_nx = (miss && !(&mismatch_cnt))
                ? mismatch_cnt + CNT_W'(1)
                : mismatch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (go) begin
      state            <= RUN;
      vec_out          <= '0;
      busy             <= 1'b1;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          vec_out <= '0;
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            vec_out <= '0;
          end else begin
            mismatch_cnt <= cnt_nx;
            if (miss && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec_out;
            end
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (cnt_nx == '0);
            end else begin
              vec_out <= vec_out + N_IN'(1);
            end
          end
        end
        DONE: begin
          if (abort) begin
            state   <= IDLE;
            done    <= 1'b0;
            pass    <= 1'b0;
            vec_out <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule
